// File: rtl/tnn_enc_pkg.sv
// tnn_enc_pkg: shared constants, state encoding and threshold triple for the TNN feature encoder.
package tnn_enc_pkg;
    localparam int N_FEAT = 7;
    localparam int RAW_W = 8;
    localparam int Q_W = 2;
    localparam int IDX_W = $clog2(N_FEAT);
    typedef enum logic {COLLECT, PRESENT} state_t;
    typedef logic [2:0][RAW_W-1:0] thr_t;
endpackage

// File: rtl/tnn_quantizer.sv
// tnn_quantizer: maps a raw sample to a 2-bit code by counting the thresholds it reaches.
module tnn_quantizer
    import tnn_enc_pkg::*;
(
    input  logic [RAW_W-1:0] x,
    input  thr_t             thr,
    output logic [Q_W-1:0]   code
);
    assign code = Q_W'(x >= thr[0]) + Q_W'(x >= thr[1]) + Q_W'(x >= thr[2]);
endmodule

// File: rtl/tnn_feature_encoder.sv
// tnn_feature_encoder: quantizes a frame of raw samples and presents the packed codes via valid/ready.
// Define TNN_ENC_THRESH_PROG_EN for per-feature programmable thresholds through the cfg_* ports.
module tnn_feature_encoder
    import tnn_enc_pkg::*;
#(
    parameter logic [RAW_W-1:0] T0 = RAW_W'(64),
    parameter logic [RAW_W-1:0] T1 = RAW_W'(128),
    parameter logic [RAW_W-1:0] T2 = RAW_W'(192)
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef TNN_ENC_THRESH_PROG_EN
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_feat,
    input  logic [1:0]              cfg_sel,
    input  logic [RAW_W-1:0]        cfg_data,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RAW_W-1:0]        in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Q_W*N_FEAT-1:0]   feat_vec,
    output logic                    frame_err
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [Q_W*N_FEAT-1:0]   vec_q, vec_d;
    logic                    err_q, err_d;
    logic [Q_W-1:0]          code;
    thr_t                    thr;
`ifdef TNN_ENC_THRESH_PROG_EN
    thr_t thr_q [N_FEAT];
    thr_t thr_d [N_FEAT];
    always_comb begin
        thr_d = thr_q;
        if (cfg_we && cfg_sel != 2'd3 && cfg_feat < IDX_W'(N_FEAT)) thr_d[cfg_feat][cfg_sel] = cfg_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_FEAT; k++) thr_q[k] <= {T2, T1, T0};
        end else begin
            thr_q <= thr_d;
        end
    end
    // Registered thresholds: a write in the accept cycle only affects later samples.
    assign thr = thr_q[idx_q];
`else
    assign thr = {T2, T1, T0};
`endif
    tnn_quantizer u_quant (
        .x    (in_data),
        .thr  (thr),
        .code (code)
    );
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == PRESENT);
    assign feat_vec  = vec_q;
    assign frame_err = err_q;
    // Unwritten slots stay zero from reset/handshake, so short frames need no explicit padding.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        err_d   = err_q;
        if (state_q == COLLECT) begin
            if (in_valid) begin
                for (int k = 0; k < N_FEAT; k++) begin
                    if (idx_q == IDX_W'(k)) vec_d[k*Q_W +: Q_W] = code;
                end
                if (idx_q == LAST_IDX || in_last) begin
                    state_d = PRESENT;
                    err_d   = (idx_q == LAST_IDX) ? ~in_last : 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end else if (out_ready) begin
            state_d = COLLECT;
            idx_d   = '0;
            vec_d   = '0;
            err_d   = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            vec_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_tnn_feature_encoder.sv
// tb_tnn_feature_encoder: directed frames checked against a queue-based frame model plus literal expectations.
module tb_tnn_feature_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [13:0] feat_vec;
    logic        frame_err;
`ifdef TNN_ENC_THRESH_PROG_EN
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_feat = 3'd0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [7:0]  cfg_data = 8'd0;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tnn_feature_encoder dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TNN_ENC_THRESH_PROG_EN
        .cfg_we    (cfg_we),
        .cfg_feat  (cfg_feat),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .feat_vec  (feat_vec),
        .frame_err (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: codes collected per frame, vector formed when the frame closes.
    int   thr_m [7][3];
    int   codes [$];
    logic exp_valid = 1'b0;
    logic [13:0] exp_vec = '0;
    logic exp_err = 1'b0;
    logic armed = 1'b0;

    function automatic int qcode(input int x, input int k);
        return int'(x >= thr_m[k][0]) + int'(x >= thr_m[k][1]) + int'(x >= thr_m[k][2]);
    endfunction

    initial for (int k = 0; k < 7; k++) begin
        thr_m[k][0] = 64;
        thr_m[k][1] = 128;
        thr_m[k][2] = 192;
    end

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            codes.delete();
            exp_valid = 1'b0;
            exp_vec = '0;
            exp_err = 1'b0;
            for (int k = 0; k < 7; k++) begin
                thr_m[k][0] = 64;
                thr_m[k][1] = 128;
                thr_m[k][2] = 192;
            end
        end else begin
            if (!exp_valid) begin
                if (in_valid) begin
                    codes.push_back(qcode(int'(in_data), codes.size()));
                    if (codes.size() == 7 || in_last) begin
                        exp_vec = '0;
                        foreach (codes[i]) exp_vec = exp_vec | (14'(codes[i]) << (2 * i));
                        exp_err = !(codes.size() == 7 && in_last);
                        exp_valid = 1'b1;
                        codes.delete();
                    end
                end
            end else if (out_ready) begin
                exp_valid = 1'b0;
                exp_vec = '0;
                exp_err = 1'b0;
            end
`ifdef TNN_ENC_THRESH_PROG_EN
            if (cfg_we && cfg_sel != 2'd3 && cfg_feat < 3'd7) thr_m[cfg_feat][cfg_sel] = int'(cfg_data);
`endif
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(!exp_valid));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("feat_vec", 32'(feat_vec), 32'(exp_vec));
                chk("frame_err", 32'(frame_err), 32'(exp_err));
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic frame7(input logic [7:0] d, input logic l);
        for (int i = 0; i < 7; i++) beat(d, l && i == 6);
    endtask

    task automatic expect_out(input string name, input logic [13:0] v, input logic e);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_vec"}, 32'(feat_vec), 32'(v));
        chk({name, "_err"}, 32'(frame_err), 32'(e));
        chk({name, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic consume();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ramp [7] = '{8'd0, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_vec", 32'(feat_vec), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) beat(ramp[i], i == 6);
        expect_out("ramp", 14'b11_11_10_10_01_01_00, 1'b0);
        consume();
        beat(8'd200, 1'b0);
        beat(8'd200, 1'b0);
        beat(8'd200, 1'b1);
        expect_out("short", 14'h003F, 1'b1);
        // Backpressure: ignored in_valid pulses while the vector is held.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 8'd255;
            in_last = 1'b1;
            @(negedge clk);
            chk("hold_vec", 32'(feat_vec), 32'h003F);
            chk("hold_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        consume();
        beat(8'd100, 1'b0);
        beat(8'd100, 1'b0);
        beat(8'd100, 1'b0);
        beat(8'd100, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        frame7(8'd255, 1'b1);
        expect_out("after_rst", 14'h3FFF, 1'b0);
        consume();
        frame7(8'd130, 1'b0);
        expect_out("long", 14'h2AAA, 1'b1);
        consume();
        // Consumer always ready: vector lives exactly one cycle.
        out_ready = 1'b1;
        frame7(8'd64, 1'b1);
        @(negedge clk);
        chk("fast_valid", 32'(out_valid), 32'd1);
        chk("fast_vec", 32'(feat_vec), 32'h1555);
        @(negedge clk);
        chk("fast_gone", 32'(out_valid), 32'd0);
        chk("fast_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        @(posedge clk); #1;
`ifdef TNN_ENC_THRESH_PROG_EN
        cfg_we = 1'b1;
        cfg_feat = 3'd2;
        cfg_sel = 2'd0;
        cfg_data = 8'd10;
        @(posedge clk); #1;
        cfg_sel = 2'd3;
        cfg_data = 8'd0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        frame7(8'd9, 1'b1);
        expect_out("prog9", 14'h0000, 1'b0);
        consume();
        frame7(8'd10, 1'b1);
        expect_out("prog10", 14'h0010, 1'b0);
        consume();
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tnn_feature_encoder.md
Name: tnn_feature_encoder

Overview:
- Upstream front end for the 7-input, 2-bit-per-input approximate TNN classifier cores (breastcancer2b family).
- Accepts a stream of raw feature samples, one per beat, and quantizes each to a 2-bit code using three thresholds.
- Packs 7 codes into a 14-bit vector and presents it through a valid/ready handshake.
- Its output drives the classifier's input_a..input_g directly: feature k maps to feat_vec[2k+1:2k].

Parameters:
- N_FEAT, 7: features per frame; classifier input count.
- RAW_W, 8: raw sample width, unsigned.
- T0, 64: default threshold 0, RAW_W bits.
- T1, 128: default threshold 1.
- T2, 192: default threshold 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  raw sample valid.
- in_ready  out  1  encoder can accept a sample.
- in_data  in  RAW_W  raw feature value, unsigned.
- in_last  in  1  marks final sample of a frame.
- out_valid  out  1  packed vector valid.
- out_ready  in  1  consumer accepts vector.
- feat_vec  out  2*N_FEAT  packed codes; feature 0 in bits [1:0].
- frame_err  out  1  qualified by out_valid; frame length was not N_FEAT.

Behaviour:
- Reset: one clock, synchronous, active-high. State=COLLECT, idx=0, feat_vec=0, out_valid=0, frame_err=0, in_ready=1. Reset mid-frame or mid-PRESENT discards all partial state.
- Quantization, combinational: code = (x>=T0) + (x>=T1) + (x>=T2), unsigned compares, sum in 2 bits.
  - Non-monotonic thresholds are still counted; the maximum is 3, so the sum never wraps.
  - Example: x=T1 exactly gives code 2.
- COLLECT state:
  - in_ready=1, out_valid=0.
  - On accept (in_valid & in_ready), the code is written to slot idx, then idx increments.
  - Accept with idx==N_FEAT-1: go to PRESENT next cycle. frame_err = ~in_last, because a missing last means the frame is too long. The upstream must then drain to its next in_last; those samples are not filtered.
  - Accept with in_last and idx<N_FEAT-1: the frame is short. Slots idx+1..N_FEAT-1 are forced to 2'b00, frame_err=1, go to PRESENT.
- PRESENT state:
  - in_ready=0, out_valid=1.
  - feat_vec and frame_err are held stable until out_ready.
  - On out_valid & out_ready: go to COLLECT, idx=0, slots cleared to 0.
  - in_ready rises the cycle after the handshake, so there is no same-cycle overlap of frames.
- Latency: out_valid asserts one cycle after the accept that completes the frame. Throughput is at most one frame per N_FEAT+1 cycles.
- out_ready held high: the vector is consumed in exactly one cycle.
- in_valid while in_ready=0 is ignored; the upstream must hold the sample.

Optional Feature:
- Macro: TNN_ENC_THRESH_PROG_EN.
- Defined:
  - Adds ports cfg_we (in 1), cfg_feat (in 3), cfg_sel (in 2), cfg_data (in RAW_W).
  - Holds per-feature threshold registers thr[feat][sel], reset to T0/T1/T2 for every feature.
  - cfg_we writes take effect from the next cycle.
  - cfg_sel==3 or cfg_feat>=N_FEAT: write ignored.
  - Writes are allowed in any state; a sample accepted in the same cycle as a write uses the old value.
- Undefined: the cfg ports do not exist, and all features use the constant parameters T0/T1/T2.

Decomposition:
- Package tnn_enc_pkg:
  - N_FEAT, RAW_W, Q_W=2 constants.
  - State enum {COLLECT, PRESENT}.
  - Threshold triple typedef (array of 3 x RAW_W).
- Sub-module tnn_quantizer: combinational; raw value plus threshold triple in, 2-bit code out. One instance per accepted beat, with thresholds muxed by idx when programmable.

Test Plan:
- Samples 0,64,127,128,191,192,255 with in_last on the 7th: feat_vec=14'b11_11_10_10_01_01_00 (feature 6 in MSBs, codes 3,3,2,2,1,1,0); frame_err=0; out_valid one cycle after the 7th accept.
- Short frame: 200,200,200 with in_last on the 3rd: feat_vec=14'h003F, frame_err=1, in_ready=0 until handshake.
- Backpressure: out_ready low 5 cycles after frame complete: feat_vec/out_valid stable; in_valid pulses ignored with in_ready=0; after out_ready, next frame accepts from idx 0.
- Reset mid-frame after 4 samples, then a full frame of 255s: feat_vec=14'h3FFF, frame_err=0, no leftover codes.
- Long frame: 7 samples with no in_last: out_valid with frame_err=1.
- TNN_ENC_THRESH_PROG_EN: write thr[2][0]=10, send 9,9,9,... (7 x 9): feat_vec slot 2=00; repeat with 10: slot 2=01, other slots 00.
